vmon_multi_chan_bus_monitor: RTL and testbench



---
 rtl/vmon_multi_chan_bus_monitor.sv | 164 ++++++++++++++++
 tb/tb_vmon_multi_chan_bus_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmon_multi_chan_bus_monitor.sv
// Snoops an SRAM-style write bus for writes to NUM_CHANNELS consecutive words and replays the
// enabled byte lanes as a channel-tagged byte stream. Optional build macro: VMON_MULTI_CHAN_TIMESTAMP_EN.
module vmon_multi_chan_bus_monitor #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR          = '0,
    parameter int                    LITTLE_ENDIAN = 1,
    parameter int                    NUM_CHANNELS  = 4,
    parameter int                    FIFO_DEPTH    = 16,
    localparam int                   BE_W          = DATA_WIDTH / 8,
    localparam int                   CHAN_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int                   LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [BE_W-1:0]       byte_en,
    input  logic                  write_en,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic [7:0]            msg_data,
    output logic [CHAN_W-1:0]     msg_chan,
    output logic                  msg_last,
`ifdef VMON_MULTI_CHAN_TIMESTAMP_EN
    output logic [31:0]           msg_timestamp,
`endif
    output logic [15:0]           overflow_cnt,
    output logic [LVL_W-1:0]      fifo_level
);
    localparam int LSB    = $clog2(BE_W);
    localparam int WORD_W = ADDR_WIDTH - LSB;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1;

    localparam logic [WORD_W-1:0] BASE_WORD = ADDR[ADDR_WIDTH-1:LSB];
    localparam logic [WORD_W-1:0] NCH_WORDS = WORD_W'(NUM_CHANNELS);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [WORD_W-1:0]     word_off;
    logic                  hit, full, push, pop, drop, fire, last_lane;
    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [15:0]           ovf_q;
    logic [CHAN_W-1:0]     mem_chan_q [FIFO_DEPTH];
    logic [BE_W-1:0]       mem_be_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [CHAN_W-1:0]     chan_q;
    logic [BE_W-1:0]       mask_q, mask_clr;
    logic [DATA_WIDTH-1:0] data_q;
    logic [LANE_W-1:0]     lane;
    logic                  unused_bits;

    // Unsigned word offset: addresses below the base wrap to large values and miss.
    assign word_off = addr[ADDR_WIDTH-1:LSB] - BASE_WORD;
    assign hit      = write_en && (byte_en != '0) && (word_off < NCH_WORDS);
    assign full     = (level_q == FULL_LVL);
    assign fire     = (state_q == S_SEND) && msg_ready;
    assign pop      = (state_q == S_FETCH) || (fire && last_lane && (level_q != '0));
    assign push     = hit && (!full || pop);
    assign drop     = hit && full && !pop;

    if (LSB > 0) begin : g_lsb
        assign unused_bits = ^addr[LSB-1:0];
    end else begin : g_no_lsb
        assign unused_bits = 1'b0;
    end

    always_comb begin
        lane = '0;
        if (LITTLE_ENDIAN != 0) begin
            for (int i = BE_W - 1; i >= 0; i--)
                if (mask_q[i]) lane = LANE_W'(i);
        end else begin
            for (int i = 0; i < BE_W; i++)
                if (mask_q[i]) lane = LANE_W'(i);
        end
    end

    always_comb begin
        mask_clr       = mask_q;
        mask_clr[lane] = 1'b0;
    end
    assign last_lane = (mask_clr == '0);

    // FETCH gives the captured entry one cycle in the FIFO before it reaches the holding register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (level_q != '0) state_d = S_FETCH;
            S_FETCH: state_d = S_SEND;
            S_SEND:  if (fire && last_lane && (level_q == '0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LVL_W'(1);
        else if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_chan_q[wr_ptr_q] <= word_off[CHAN_W-1:0];
            mem_be_q[wr_ptr_q]   <= byte_en;
            mem_data_q[wr_ptr_q] <= data;
        end
        if (pop) begin
            chan_q <= mem_chan_q[rd_ptr_q];
            mask_q <= mem_be_q[rd_ptr_q];
            data_q <= mem_data_q[rd_ptr_q];
        end else if (fire) begin
            mask_q <= mask_clr;
        end
    end

`ifdef VMON_MULTI_CHAN_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] mem_ts_q [FIFO_DEPTH];
    logic [31:0] ts_hold_q;

    always_ff @(posedge clk) begin
        if (reset) ts_cnt_q <= '0;
        else       ts_cnt_q <= ts_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_ts_q[wr_ptr_q] <= ts_cnt_q;
        if (pop)  ts_hold_q <= mem_ts_q[rd_ptr_q];
    end

    assign msg_timestamp = msg_valid ? ts_hold_q : 32'd0;
`endif

    // Outputs are forced to zero outside SEND so the unreset holding register never leaks out.
    assign msg_valid    = (state_q == S_SEND);
    assign msg_data     = msg_valid ? data_q[8*lane +: 8] : 8'h00;
    assign msg_chan     = msg_valid ? chan_q : '0;
    assign msg_last     = msg_valid && last_lane;
    assign overflow_cnt = ovf_q;
    assign fifo_level   = level_q;
endmodule

// File: tb/tb_vmon_multi_chan_bus_monitor.sv
// Bench for vmon_multi_chan_bus_monitor: two instances (little-endian at base 0, big-endian at
// base 'h100) share one bus; a queue-based reference model predicts every emitted byte.
module tb_vmon_multi_chan_bus_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, data;
    logic [3:0]  byte_en;
    logic        write_en, msg_ready;
    logic        mon_en;

    logic        le_valid, le_last, be_valid, be_last;
    logic [7:0]  le_data, be_data;
    logic [1:0]  le_chan, be_chan;
    logic [15:0] le_ovf, be_ovf;
    logic [4:0]  le_level, be_level;
`ifdef VMON_MULTI_CHAN_TIMESTAMP_EN
    logic [31:0] le_ts, be_ts;
`endif

    always #5 clk = ~clk;

    vmon_multi_chan_bus_monitor #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR(32'h0000_0000),
        .LITTLE_ENDIAN(1), .NUM_CHANNELS(4), .FIFO_DEPTH(16)
    ) u_le (
        .clk(clk), .reset(reset), .addr(addr), .data(data), .byte_en(byte_en),
        .write_en(write_en), .msg_valid(le_valid), .msg_ready(msg_ready),
        .msg_data(le_data), .msg_chan(le_chan), .msg_last(le_last),
`ifdef VMON_MULTI_CHAN_TIMESTAMP_EN
        .msg_timestamp(le_ts),
`endif
        .overflow_cnt(le_ovf), .fifo_level(le_level)
    );

    vmon_multi_chan_bus_monitor #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR(32'h0000_0100),
        .LITTLE_ENDIAN(0), .NUM_CHANNELS(4), .FIFO_DEPTH(16)
    ) u_be (
        .clk(clk), .reset(reset), .addr(addr), .data(data), .byte_en(byte_en),
        .write_en(write_en), .msg_valid(be_valid), .msg_ready(msg_ready),
        .msg_data(be_data), .msg_chan(be_chan), .msg_last(be_last),
`ifdef VMON_MULTI_CHAN_TIMESTAMP_EN
        .msg_timestamp(be_ts),
`endif
        .overflow_cnt(be_ovf), .fifo_level(be_level)
    );

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t q_le[$];
    exp_t q_be[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Reference: a write inside [base, base+16) produces its enabled bytes in lane order.
    task automatic model_write(input int which, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be);
        logic [31:0] base;
        bit          little;
        int          lanes[$];
        exp_t        e;
        base   = (which == 0) ? 32'h0000_0000 : 32'h0000_0100;
        little = (which == 0);
        if (be == 4'h0 || a < base || a >= base + 32'd16) return;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = little ? k : 3 - k;
            if (be[i]) lanes.push_back(i);
        end
        for (int k = 0; k < lanes.size(); k++) begin
            e.chan = 2'((a - base) / 4);
            e.b    = d[8*lanes[k] +: 8];
            e.last = (k == lanes.size() - 1);
            if (which == 0) q_le.push_back(e);
            else            q_be.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input bit model);
        addr     = a;
        data     = d;
        byte_en  = be;
        write_en = 1'b1;
        if (model) begin
            model_write(0, a, d, be);
            model_write(1, a, d, be);
        end
        tick(1);
        write_en = 1'b0;
    endtask

    task automatic wait_le_valid(input string tag);
        int w;
        w = 0;
        while (!le_valid && w < 20) begin
            tick(1);
            w++;
        end
        chk(tag, le_valid, 1'b1);
    endtask

    logic       le_pv = 1'b0, le_pr = 1'b0, be_pv = 1'b0, be_pr = 1'b0;
    logic [10:0] le_prev, be_prev;

    always @(negedge clk) begin
        if (mon_en && le_valid) begin
            if (le_pv && !le_pr) chk("le_stall_stable", {le_chan, le_data, le_last}, le_prev);
            if (msg_ready) begin
                chk("le_byte_expected", q_le.size() != 0, 1'b1);
                if (q_le.size() != 0) chk("le_byte", {le_chan, le_data, le_last}, q_le.pop_front());
            end
        end
        le_pv   = le_valid;
        le_pr   = msg_ready;
        le_prev = {le_chan, le_data, le_last};
    end

    always @(negedge clk) begin
        if (mon_en && be_valid) begin
            if (be_pv && !be_pr) chk("be_stall_stable", {be_chan, be_data, be_last}, be_prev);
            if (msg_ready) begin
                chk("be_byte_expected", q_be.size() != 0, 1'b1);
                if (q_be.size() != 0) chk("be_byte", {be_chan, be_data, be_last}, q_be.pop_front());
            end
        end
        be_pv   = be_valid;
        be_pr   = msg_ready;
        be_prev = {be_chan, be_data, be_last};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; write_en = 1'b0; addr = '0; data = '0; byte_en = '0;
        msg_ready = 1'b0; mon_en = 1'b0;
        tick(3);
        chk("rst_le_valid", le_valid, 1'b0);
        chk("rst_le_data",  le_data,  8'h00);
        chk("rst_le_chan",  le_chan,  2'd0);
        chk("rst_le_last",  le_last,  1'b0);
        chk("rst_le_ovf",   le_ovf,   16'd0);
        chk("rst_le_level", le_level, 5'd0);
        chk("rst_be_valid", be_valid, 1'b0);
        chk("rst_be_level", be_level, 5'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single write, latency and lane order.
        msg_ready = 1'b1;
        bus_write(32'h4, 32'hDDCC_BBAA, 4'hF, 1'b1);
        chk("lat_level_E",  le_level, 5'd1);
        chk("lat_valid_E",  le_valid, 1'b0);
        tick(1);
        chk("lat_valid_E1", le_valid, 1'b0);
        tick(1);
        chk("lat_valid_E2", le_valid, 1'b1);
        chk("first_data",   le_data,  8'hAA);
        chk("first_chan",   le_chan,  2'd1);
        tick(8);
        chk("t1_le_drained", q_le.size(), 0);

        // Big-endian partial write.
        bus_write(32'h104, 32'hDDCC_BBAA, 4'b0101, 1'b1);
        tick(8);
        chk("t2_be_drained", q_be.size(), 0);

        // Out-of-window and empty-enable writes.
        bus_write(32'h10,  32'h1111_1111, 4'hF, 1'b1);
        bus_write(32'hFC,  32'h2222_2222, 4'hF, 1'b1);
        bus_write(32'h4,   32'h3333_3333, 4'h0, 1'b1);
        bus_write(32'h110, 32'h4444_4444, 4'hF, 1'b1);
        tick(8);
        chk("filt_le_ovf",   le_ovf,   16'd0);
        chk("filt_be_ovf",   be_ovf,   16'd0);
        chk("filt_le_level", le_level, 5'd0);
        chk("filt_be_level", be_level, 5'd0);
        chk("filt_le_q",     q_le.size(), 0);
        chk("filt_be_q",     q_be.size(), 0);

        // Overflow: one entry held, sixteen buffered, four dropped.
        msg_ready = 1'b0;
        bus_write(32'h0, 32'h5000_0000, 4'hF, 1'b1);
        tick(4);
        for (int i = 1; i <= 20; i++) bus_write(32'h0, 32'h5000_0000 + i, 4'hF, i <= 16);
        chk("ovf_level", le_level, 5'd16);
        chk("ovf_cnt",   le_ovf,   16'd4);
        chk("ovf_be_level", be_level, 5'd0);
        msg_ready = 1'b1;
        tick(17 * 4 + 10);
        chk("ovf_drained", q_le.size(), 0);
        chk("ovf_level_end", le_level, 5'd0);
        chk("ovf_cnt_hold", le_ovf, 16'd4);

        // Backpressure with ready toggling every cycle.
        msg_ready = 1'b0;
        bus_write(32'h8, 32'h4433_2211, 4'hF, 1'b1);
        repeat (16) begin
            msg_ready = ~msg_ready;
            tick(1);
        end
        msg_ready = 1'b1;
        tick(4);
        chk("bp_drained", q_le.size(), 0);

        // Back-to-back entries with no idle cycle.
        bus_write(32'h8, 32'h8877_6655, 4'hF, 1'b1);
        bus_write(32'hC, 32'hCCBB_AA99, 4'hF, 1'b1);
        wait_le_valid("b2b_start");
        repeat (8) begin
            chk("b2b_no_bubble", le_valid, 1'b1);
            tick(1);
        end
        tick(2);
        chk("b2b_idle_after", le_valid, 1'b0);
        chk("b2b_drained", q_le.size(), 0);

        // Reset in the middle of an entry.
        msg_ready = 1'b0;
        bus_write(32'h0, 32'h0D0C_0B0A, 4'hF, 1'b1);
        wait_le_valid("mid_rst_start");
        msg_ready = 1'b1;
        tick(2);
        msg_ready = 1'b0;
        reset     = 1'b1;
        tick(1);
        q_le.delete();
        q_be.delete();
        chk("mid_rst_valid", le_valid, 1'b0);
        chk("mid_rst_level", le_level, 5'd0);
        chk("mid_rst_ovf",   le_ovf,   16'd0);
        chk("mid_rst_data",  le_data,  8'h00);
        reset     = 1'b0;
        msg_ready = 1'b1;
        bus_write(32'h4, 32'h1122_3344, 4'b0110, 1'b1);
        tick(8);
        chk("post_rst_drained", q_le.size(), 0);

        // Randomized traffic around both windows.
        for (int c = 0; c < 400; c++) begin
            msg_ready = ($urandom_range(3) != 0);
            if ($urandom_range(5) == 0) begin
                logic [31:0] a;
                a = (($urandom_range(1) == 0) ? 32'h0 : 32'h100)
                    + 32'($urandom_range(7)) * 4 - 32'd8 + 32'($urandom_range(3));
                bus_write(a, $urandom, 4'($urandom_range(15)), 1'b1);
            end else begin
                tick(1);
            end
        end
        msg_ready = 1'b1;
        tick(100);
        chk("rand_le_drained", q_le.size(), 0);
        chk("rand_be_drained", q_be.size(), 0);
        chk("rand_le_ovf", le_ovf, 16'd0);
        chk("rand_be_ovf", be_ovf, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
